mux_nx1_stream: RTL
===================

// Module: mux_nx1_stream
// PURPOSE
//  Parametrised N-input, W-bit registered stream multiplexer with per-channel valid/ready handshake.
//  Selects one requesting input per cycle by round-robin, fixed priority, or external select.
//  Presents the selection through a one-entry output register with its source channel index.
//  Sits between multiple producers and a single shared consumer; generalises the 4x1 data mux to streams.
// PARAMETERS
//  N     4  number of input channels, N >= 2
//  W     4  data width per channel, W >= 1
//  MODE  0  0 = round-robin; 1 = fixed priority, lowest index wins; 2 = external select via sel
//  CW    $clog2(N)  channel index width (local, derived)
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_data    in   N*W   channel i data at [i*W +: W]
//  in_valid   in   N     channel i presents data
//  in_ready   out  N     channel i transfers this cycle when in_valid[i] & in_ready[i]
//  sel        in   CW    channel to serve; used only when MODE=2
//  out_data   out  W     registered selected data
//  out_valid  out  1     out_data holds an untaken word
//  out_ready  in   1     consumer accepts; transfer when out_valid & out_ready
//  out_chan   out  CW    source channel index of out_data
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
//  Reset mid-transfer discards the held word; nothing is replayed after release.
//  Load enable: ld = ~out_valid | out_ready (register empty or draining this cycle).
//  Grant is combinational, one-hot or zero, from in_valid and mode:
//   MODE0: first valid index scanning rr_ptr, rr_ptr+1, ... mod N (wraps N-1 -> 0).
//   MODE1: lowest valid index.
//   MODE2: index sel when in_valid[sel]; else none. sel >= N (non-power-of-2 N) grants none.
//  in_ready = grant & {N{ld}}; at most one bit set per cycle. Path out_ready -> in_ready is combinational.
//  On transfer from channel g: out_data <= in_data[g*W +: W], out_chan <= g, out_valid <= 1.
//  If ld and no grant: out_valid <= 0; out_data and out_chan hold previous values.
//  While out_valid & ~out_ready: out_data, out_chan, out_valid held stable; all in_ready = 0.
//  Latency: input transfer at edge k -> word visible at out_* after edge k; 1 cycle.
//  Throughput: one word per cycle with out_ready held high (simultaneous drain and load).
//  rr_ptr (MODE0 only): updates to (g+1) mod N only on an input transfer; unchanged on stall or idle.
//  Fairness MODE0: a continuously valid channel is served within N transfers.
//  in_valid deasserting without a transfer is tolerated; no state is kept for it.
//  No X is driven on any output at any time.
// TESTING
//  T1 reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, no clk needed.
//  T2 MODE0, N=4, all in_valid=1, out_ready=1, data ch i = 4'hA+i -> out_chan 0,1,2,3,0; out_data A,B,C,D,A; one word per cycle.
//  T3 MODE0 backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_chan frozen, in_ready=0, rr_ptr unchanged; release -> next channel in order.
//  T4 MODE1, in_valid=4'b1010 -> out_chan=1 each cycle, ch3 starves; clear in_valid[1] -> out_chan=3.
//  T5 MODE2, sel=2, in_valid=4'b0100, data2=4'h5 -> out_data=5, out_chan=2; sel=3 with in_valid[3]=0 -> out_valid=0 after next edge.
//  T6 random N=5, W=8, random valids/out_ready, all modes -> scoreboard: no loss, no duplication, per-channel order kept, out_chan matches source.

Source files
------------

// File: rtl/mux_nx1_stream.sv
// N-input registered stream multiplexer with valid/ready handshake on every channel.
// It arbitrates by round-robin, fixed priority or external select, and holds the result in a one-entry output register.
module mux_nx1_stream #(
    parameter  int N    = 4,
    parameter  int W    = 4,
    parameter  int MODE = 0,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [CW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_chan
);

    logic [W-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_chan_q,  out_chan_d;
    logic [CW-1:0] rr_ptr_q,    rr_ptr_d;

    logic          ld;
    logic          found;
    logic [CW-1:0] g_idx;
    logic [N-1:0]  grant;
    logic [W-1:0]  g_data;

    assign ld = ~out_valid_q | out_ready;

    always_comb begin
        found = 1'b0;
        g_idx = '0;
        if (MODE == 0) begin
            // Scan a doubled index range from rr_ptr. The first valid hit always lies in [rr_ptr, rr_ptr+N).
            for (int k = 0; k < 2*N; k++) begin
                if (!found && (k >= int'(rr_ptr_q)) && in_valid[k % N]) begin
                    found = 1'b1;
                    g_idx = CW'(k % N);
                end
            end
        end else if (MODE == 1) begin
            for (int i = 0; i < N; i++) begin
                if (!found && in_valid[i]) begin
                    found = 1'b1;
                    g_idx = CW'(i);
                end
            end
        end else begin
            // A select value of N or above matches no channel, so it grants nothing.
            for (int i = 0; i < N; i++) begin
                if (!found && (sel == CW'(i)) && in_valid[i]) begin
                    found = 1'b1;
                    g_idx = CW'(i);
                end
            end
        end
    end

    always_comb begin
        grant  = '0;
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (found && (g_idx == CW'(i))) begin
                grant[i] = 1'b1;
                g_data   = in_data[i*W +: W];
            end
        end
    end

    assign in_ready = grant & {N{ld}};

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (ld) begin
            if (found) begin
                out_data_d  = g_data;
                out_chan_d  = g_idx;
                out_valid_d = 1'b1;
                rr_ptr_d    = (g_idx == CW'(N-1)) ? '0 : g_idx + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule
